// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the bsg_cgol byte loader.
//   state_e           packet framing state (header word, then board words)
//   word_width_gp     width of a bsg_cgol packet word
//   byte_width_gp     width of one host byte
//   bytes_per_word_gp host bytes assembled into one packet word
//   safe_clog2        ceil(log2(x)), never smaller than 1
package bsg_cgol_pkg;

  localparam int word_width_gp     = 64;
  localparam int byte_width_gp     = 8;
  localparam int bytes_per_word_gp = 8;

  typedef enum logic {
    eHDR,
    eBOARD
  } state_e;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_cgol_byte_assembler.sv
// Collects eight host bytes into one 64-bit word, little-endian
// (first byte lands in bits [7:0]).
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   data_i, v_i     host byte and its valid
//   ready_o         high while fewer than eight bytes are held
//   clear_i         the held word has been consumed; restart at lane 0
//   full_o          eight bytes held
//   data_o          assembled word
module bsg_cgol_byte_assembler
  import bsg_cgol_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [byte_width_gp-1:0] data_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     clear_i,
  output logic                     full_o,
  output logic [word_width_gp-1:0] data_o
);

  logic [3:0]               byte_cnt_r;
  logic [word_width_gp-1:0] word_r;

  assign full_o  = (byte_cnt_r == 4'd8);
  assign ready_o = ~full_o;
  assign data_o  = word_r;

  // clear_i only arrives when full, so it never collides with a byte handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_cnt_r <= '0;
      word_r     <= '0;
    end else if (clear_i) begin
      byte_cnt_r <= '0;
    end else if (v_i & ready_o) begin
      word_r[{byte_cnt_r[2:0], 3'b000} +: byte_width_gp] <= data_i;
      byte_cnt_r <= byte_cnt_r + 4'd1;
    end
  end

endmodule

// File: rtl/bsg_cgol_byte_loader.sv
// Upstream feeder for bsg_cgol: turns a host byte stream into framed
// 64-bit packets (one header word holding the game length, then the
// board words, cell 0 in bit 0 of the first board word).
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   data_i, v_i, ready_o host byte stream (valid/ready)
//   data_o, v_o, ready_i packet word stream towards bsg_cgol
//   packet_done_o        pulses on handoff of a packet's last word
// Build option BSG_CGOL_LOADER_CLAMP_EN: header values above
// max_game_length_p are replaced by max_game_length_p; otherwise the header
// is truncated to its low glw_lp bits.
module bsg_cgol_byte_loader
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p     = 8,
  parameter int max_game_length_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [byte_width_gp-1:0] data_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [word_width_gp-1:0] data_o,
  output logic                     v_o,
  input  logic                     ready_i,
  output logic                     packet_done_o
);

  localparam int cells_lp     = board_width_p * board_width_p;
  localparam int words_lp     = (cells_lp + word_width_gp - 1) / word_width_gp;
  localparam int tail_bits_lp = cells_lp - word_width_gp * (words_lp - 1);
  localparam int glw_lp       = safe_clog2(max_game_length_p);
  localparam int wcw_lp       = safe_clog2(words_lp);

  localparam logic [word_width_gp-1:0] tail_mask_lp =
    (tail_bits_lp >= word_width_gp) ? '1 : ((64'(1) << tail_bits_lp) - 64'(1));
`ifdef BSG_CGOL_LOADER_CLAMP_EN
  localparam logic [word_width_gp-1:0] max_len_lp = 64'(max_game_length_p);
`else
  localparam logic [word_width_gp-1:0] hdr_mask_lp =
    (glw_lp >= word_width_gp) ? '1 : ((64'(1) << glw_lp) - 64'(1));
`endif
  localparam logic [wcw_lp-1:0] last_word_lp = wcw_lp'(words_lp - 1);

  logic                     asm_full;
  logic [word_width_gp-1:0] asm_data;
  logic                     xfer;

  state_e                   state_r, state_n;
  logic [wcw_lp-1:0]        word_cnt_r, word_cnt_n;
  logic [word_width_gp-1:0] proc_word;
  logic                     last_word;

  logic [word_width_gp-1:0] data_r;
  logic                     v_r;
  logic                     done_r;

  bsg_cgol_byte_assembler assembler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .clear_i (xfer),
    .full_o  (asm_full),
    .data_o  (asm_data)
  );

  // The out reg accepts a new word when empty or when its word leaves this cycle.
  assign xfer = asm_full & (~v_r | ready_i);

  always_comb begin
    state_n    = state_r;
    word_cnt_n = word_cnt_r;
    proc_word  = asm_data;
    last_word  = 1'b0;
    case (state_r)
      eHDR: begin
`ifdef BSG_CGOL_LOADER_CLAMP_EN
        proc_word = (asm_data > max_len_lp) ? max_len_lp : asm_data;
`else
        proc_word = asm_data & hdr_mask_lp;
`endif
        if (xfer) begin
          state_n    = eBOARD;
          word_cnt_n = '0;
        end
      end
      eBOARD: begin
        if (word_cnt_r == last_word_lp) begin
          proc_word = asm_data & tail_mask_lp;
          last_word = 1'b1;
          if (xfer) begin
            state_n    = eHDR;
            word_cnt_n = '0;
          end
        end else if (xfer) begin
          word_cnt_n = word_cnt_r + 1'b1;
        end
      end
      default: state_n = eHDR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= eHDR;
      word_cnt_r <= '0;
      data_r     <= '0;
      v_r        <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      word_cnt_r <= word_cnt_n;
      if (xfer) begin
        data_r <= proc_word;
        v_r    <= 1'b1;
        done_r <= last_word;
      end else if (ready_i) begin
        v_r    <= 1'b0;
        done_r <= 1'b0;
      end
    end
  end

  assign data_o        = data_r;
  assign v_o           = v_r;
  assign packet_done_o = v_r & ready_i & done_r;

endmodule

// File: tb/tb_bsg_cgol_byte_loader.sv
module tb_bsg_cgol_byte_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // dut_a: 8x8 board (one board word), max length 16
  logic [7:0]  a_data;
  logic        a_v, a_ready, a_vo, a_done;
  logic        a_rdy;
  logic [63:0] a_out;

  // dut_b: 10x10 board (two board words, 36-bit tail), max length 16
  logic [7:0]  b_data;
  logic        b_v, b_ready, b_vo, b_done;
  logic        b_rdy = 1'b1;
  logic        b_rand = 1'b0;
  logic [63:0] b_out;

  int checks = 0;
  int failures = 0;

  logic [63:0] qa_data[$];
  logic        qa_done[$];
  logic [63:0] qb_data[$];
  logic        qb_done[$];

  bsg_cgol_byte_loader #(.board_width_p(8), .max_game_length_p(16)) dut_a (
    .clk_i(clk), .reset_i(reset), .data_i(a_data), .v_i(a_v), .ready_o(a_ready),
    .data_o(a_out), .v_o(a_vo), .ready_i(a_rdy), .packet_done_o(a_done));

  bsg_cgol_byte_loader #(.board_width_p(10), .max_game_length_p(16)) dut_b (
    .clk_i(clk), .reset_i(reset), .data_i(b_data), .v_i(b_v), .ready_o(b_ready),
    .data_o(b_out), .v_o(b_vo), .ready_i(b_rdy), .packet_done_o(b_done));

  // Output monitors: a word is handed off at the next posedge when v_o & ready_i.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_vo && a_rdy) begin
        qa_data.push_back(a_out);
        qa_done.push_back(a_done);
      end
      if (b_vo && b_rdy) begin
        qb_data.push_back(b_out);
        qb_done.push_back(b_done);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    b_rdy = b_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  function automatic logic [63:0] hdr_model(input logic [63:0] h);
`ifdef BSG_CGOL_LOADER_CLAMP_EN
    return (h > 64'd16) ? 64'd16 : h;
`else
    return h & 64'hF;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_a(input logic [7:0] b);
    int n = 0;
    a_data = b;
    a_v = 1'b1;
    @(negedge clk);
    while (!a_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      checks++; failures++;
      $display("FAIL send_a_timeout ready_o=%0b required 1", a_ready);
    end
    @(posedge clk); #1;
    a_v = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    int n = 0;
    int g;
    g = b_rand ? $urandom_range(0, 2) : 0;
    repeat (g) begin @(posedge clk); #1; end
    b_data = b;
    b_v = 1'b1;
    @(negedge clk);
    while (!b_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!b_ready) begin
      checks++; failures++;
      $display("FAIL send_b_timeout ready_o=%0b required 1", b_ready);
    end
    @(posedge clk); #1;
    b_v = 1'b0;
  endtask

  task automatic send_word_a(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_a(w[i*8 +: 8]);
  endtask

  task automatic send_word_b(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_b(w[i*8 +: 8]);
  endtask

  task automatic wait_qa(input int n);
    int c = 0;
    while (qa_data.size() < n && c < 2000) begin @(posedge clk); c++; end
    #1;
    checks++;
    if (qa_data.size() < n) begin
      failures++;
      $display("FAIL wait_qa words=%0d required %0d", qa_data.size(), n);
    end
  endtask

  task automatic wait_qb(input int n, input int budget);
    int c = 0;
    while (qb_data.size() < n && c < budget) begin @(posedge clk); c++; end
    #1;
    checks++;
    if (qb_data.size() < n) begin
      failures++;
      $display("FAIL wait_qb words=%0d required %0d", qb_data.size(), n);
    end
  endtask

  task automatic check_a(input string name, input int idx, input logic [63:0] d, input logic dn);
    // local helper keeps indexing safe; each call site is its own comparison
    checks++;
    if (idx >= qa_data.size()) begin
      failures++;
      $display("FAIL %s missing word %0d", name, idx);
    end else if (qa_data[idx] !== d || qa_done[idx] !== dn) begin
      failures++;
      $display("FAIL %s data=%h done=%0b required data=%h done=%0b", name, qa_data[idx], qa_done[idx], d, dn);
    end
  endtask

  task automatic test_reset();
    checks += 8;
    if (a_vo !== 1'b0)    begin failures++; $display("FAIL reset_a_v v_o=%0b required 0", a_vo); end
    if (a_out !== 64'd0)  begin failures++; $display("FAIL reset_a_data data_o=%h required 0", a_out); end
    if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready ready_o=%0b required 1", a_ready); end
    if (a_done !== 1'b0)  begin failures++; $display("FAIL reset_a_done done=%0b required 0", a_done); end
    if (b_vo !== 1'b0)    begin failures++; $display("FAIL reset_b_v v_o=%0b required 0", b_vo); end
    if (b_out !== 64'd0)  begin failures++; $display("FAIL reset_b_data data_o=%h required 0", b_out); end
    if (b_ready !== 1'b1) begin failures++; $display("FAIL reset_b_ready ready_o=%0b required 1", b_ready); end
    if (b_done !== 1'b0)  begin failures++; $display("FAIL reset_b_done done=%0b required 0", b_done); end
  endtask

  task automatic test_basic();
    a_rdy = 1'b1;
    send_word_a(64'h5);
    @(negedge clk);
    checks++;
    if (a_vo !== 1'b0 || a_ready !== 1'b0) begin
      failures++;
      $display("FAIL latency_t1 v_o=%0b ready_o=%0b required 0 0", a_vo, a_ready);
    end
    @(negedge clk);
    checks++;
    if (a_vo !== 1'b1 || a_out !== 64'h5) begin
      failures++;
      $display("FAIL latency_t2 v_o=%0b data_o=%h required 1 5", a_vo, a_out);
    end
    @(posedge clk); #1;
    send_word_a(64'hAAAA_AAAA_AAAA_AAAA);
    wait_qa(2);
    check_a("basic_hdr", 0, 64'h5, 1'b0);
    check_a("basic_board", 1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    repeat (3) @(posedge clk); #1;
    qa_data.delete(); qa_done.delete();
  endtask

  task automatic test_tail_mask();
    send_word_b(64'h3);
    send_word_b(64'hFFFF_FFFF_FFFF_FFFF);
    send_word_b(64'hFFFF_FFFF_FFFF_FFFF);
    wait_qb(3, 2000);
    checks++;
    if (qb_data.size() < 3 || qb_data[0] !== 64'h3 || qb_data[1] !== 64'hFFFF_FFFF_FFFF_FFFF ||
        qb_data[2] !== 64'h0000_000F_FFFF_FFFF || qb_done[1] !== 1'b0 || qb_done[2] !== 1'b1) begin
      failures++;
      if (qb_data.size() >= 3)
        $display("FAIL tail_mask words=%h %h %h done=%0b required 3 ffffffffffffffff 0000000fffffffff done=1",
                 qb_data[0], qb_data[1], qb_data[2], qb_done[2]);
      else
        $display("FAIL tail_mask words=%0d required 3", qb_data.size());
    end
    qb_data.delete(); qb_done.delete();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    a_rdy = 1'b0;
    send_word_a(64'h7);
    send_word_a(64'h1817_1615_1413_1211);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_vo !== 1'b1 || a_out !== 64'h7 || a_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold bad_cycles=%0d required 0 (v_o=%0b data_o=%h ready_o=%0b)", bad, a_vo, a_out, a_ready);
    end
    checks++;
    if (qa_data.size() != 0) begin
      failures++;
      $display("FAIL stall_no_handoff words=%0d required 0", qa_data.size());
    end
    @(posedge clk); #1;
    a_rdy = 1'b1;
    send_word_a(64'h9);
    send_word_a(64'h0807_0605_0403_0201);
    wait_qa(4);
    check_a("stall_w0", 0, 64'h7, 1'b0);
    check_a("stall_w1", 1, 64'h1817_1615_1413_1211, 1'b1);
    check_a("stall_w2", 2, 64'h9, 1'b0);
    check_a("stall_w3", 3, 64'h0807_0605_0403_0201, 1'b1);
    repeat (3) @(posedge clk); #1;
    qa_data.delete(); qa_done.delete();
  endtask

  task automatic test_header_range();
    logic [63:0] e64, e16;
`ifdef BSG_CGOL_LOADER_CLAMP_EN
    e64 = 64'h10; e16 = 64'h10;
`else
    e64 = 64'h4;  e16 = 64'h0;
`endif
    send_word_a(64'h64);
    send_word_a(64'h5A5A_5A5A_5A5A_5A5A);
    send_word_a(64'h10);
    send_word_a(64'h1);
    send_word_a(64'h0);
    send_word_a(64'h2);
    wait_qa(6);
    check_a("hdr_0x64", 0, e64, 1'b0);
    check_a("hdr_0x64_board", 1, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1);
    check_a("hdr_max", 2, e16, 1'b0);
    check_a("hdr_zero", 4, 64'h0, 1'b0);
    repeat (3) @(posedge clk); #1;
    qa_data.delete(); qa_done.delete();
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 0; i < 11; i++) send_a(8'(8'hE0 + i));
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    qa_data.delete(); qa_done.delete();
    send_word_a(64'hC);
    send_word_a(64'h3837_3635_3433_3231);
    wait_qa(2);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (qa_data.size() != 2) begin
      failures++;
      $display("FAIL reset_mid_count words=%0d required 2", qa_data.size());
    end
    check_a("reset_mid_hdr", 0, 64'hC, 1'b0);
    check_a("reset_mid_board", 1, 64'h3837_3635_3433_3231, 1'b1);
    qa_data.delete(); qa_done.delete();
  endtask

  task automatic test_random();
    logic [63:0] exp_d[$];
    logic        exp_dn[$];
    logic [63:0] h, w1, w2;
    b_rand = 1'b1;
    for (int p = 0; p < 100; p++) begin
      h  = (p % 3 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 20));
      w1 = {$urandom, $urandom};
      w2 = {$urandom, $urandom};
      exp_d.push_back(hdr_model(h));                  exp_dn.push_back(1'b0);
      exp_d.push_back(w1);                            exp_dn.push_back(1'b0);
      exp_d.push_back(w2 & 64'h0000_000F_FFFF_FFFF);  exp_dn.push_back(1'b1);
      send_word_b(h);
      send_word_b(w1);
      send_word_b(w2);
    end
    wait_qb(300, 20000);
    for (int i = 0; i < 300; i++) begin
      checks++;
      if (i >= qb_data.size()) begin
        failures++;
        $display("FAIL random_word%0d missing", i);
      end else if (qb_data[i] !== exp_d[i] || qb_done[i] !== exp_dn[i]) begin
        failures++;
        $display("FAIL random_word%0d data=%h done=%0b required data=%h done=%0b",
                 i, qb_data[i], qb_done[i], exp_d[i], exp_dn[i]);
      end
    end
    b_rand = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_data = '0; a_v = 1'b0; a_rdy = 1'b1;
    b_data = '0; b_v = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_tail_mask();
    test_backpressure();
    test_header_range();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
